cg_fetch_sequencer: RTL
=======================

Name: cg_fetch_sequencer

Overview:
Sequences character-generator ROM access for the text display. Per character cell it reads a character code from VRAM, forms the CG ROM address {code, scan line}, captures the font byte and serialises it to a 1-bit pixel stream. Sits between the video timing generator, VRAM read port and the 2 KB CG ROM (256 chars × 8 lines, combinational read with output enable). Prefetches one cell ahead so the pixel output is gap-free.

Parameters:
COLS, 40, character cells per display line
VRAM_AW, 11, VRAM address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ce_pix  in  1  pixel clock enable, at most one per clk
line_start  in  1  one-clk pulse; at least 8 ce_pix before de rises
de  in  1  active display, qualified by ce_pix
row_base  in  VRAM_AW  VRAM address of column 0 of current text row, sampled on line_start
row_line  in  3  scan line within character row, sampled on line_start
reverse  in  1  invert pixel output
vram_addr  out  VRAM_AW  VRAM read address
vram_rd  out  1  VRAM read strobe
vram_data  in  8  character code, valid the clk after vram_rd
cg_addr  out  11  CG ROM address {code, line}
cg_en  out  1  CG ROM output enable
cg_data  in  8  CG ROM data, valid same clk as cg_addr/cg_en
pix  out  1  serial pixel, MSB of font byte first
underrun  out  1  one-clk pulse: cell load with no font byte pending

Behaviour:
- Reset: all outputs 0; FSM IDLE; col=0, ptr=0, phase=0, shift=0, pending=0, pending_valid=0; line registers 0.
- line_start (highest priority; aborts any fetch in progress, FSM to RD_CODE next clk): ptr<=row_base, line<=row_line, col<=0, pending_valid<=0, phase<=0.
- Fetch FSM, one state per clk, not gated by ce_pix:
  IDLE: wait for trigger.
  RD_CODE: vram_rd=1, vram_addr=ptr.
  LAT_CODE: code<=vram_data; registered cg_addr<={code,line}, cg_en=1 during next state.
  LAT_FONT: pending<=cg_data, pending_valid<=1, ptr<=ptr+1 (wraps mod 2^VRAM_AW), col<=col+1; -> IDLE.
  cg_en high only in LAT_FONT; vram_rd high only in RD_CODE. Fetch latency 3 clk, well under 8 ce_pix.
- Triggers: line_start; cell load (below) while col<COLS. Exactly COLS fetches per line; none when col==COLS.
- Pixel path, on ce_pix with de=1:
  phase==0: shift<=pending<<1; pix<=pending[7]^reverse; pending_valid<=0; trigger fetch if col<COLS. If pending_valid=0: loads 0x00, underrun pulse.
  phase!=0: pix<=shift[7]^reverse; shift<=shift<<1.
  phase<=phase+1 mod 8.
- ce_pix with de=0: pix<=0 (not inverted), phase<=0, pending retained.
- No ce_pix: pix, shift, phase hold.
- Cells beyond COLS while de high: blank 0x00 (underrun pulses each such cell).
- Trigger arriving while FSM busy (only possible with line_start): line_start wins; cell-load trigger while busy is impossible by construction.
- Async reset mid-fetch: immediate return to reset state; no partial strobes.

Test Plan:
- Reset: assert rst_n=0 mid-fetch -> vram_rd, cg_en, pix, underrun all 0 immediately; FSM IDLE after release.
- Single line: row_base=0x100, row_line=3, VRAM[0x100]=0x41, ROM[0x20B]=0x18, ce_pix every clk -> vram_addr 0x100, cg_addr 0x20B, pix sequence 0,0,0,1,1,0,0,0 for cell 0.
- reverse=1, same data -> pix 1,1,1,0,0,1,1,1; de=0 -> pix 0.
- Full line, ce_pix every 2 clk, COLS=40 -> exactly 40 vram_rd pulses, addresses 0x100..0x127, no underrun; cell 41 with de high -> 0x00 + underrun pulse.
- Wrap: row_base=0x7FF -> second fetch address 0x000.
- line_start asserted during LAT_CODE -> fetch aborted, restarts at new row_base, pending_valid cleared, first cell correct.

Source files
------------

// File: rtl/cg_fetch_sequencer.sv
// cg_fetch_sequencer
// Fetches character codes from VRAM and font bytes from the CG ROM, one cell
// ahead of the pixel shifter, and serialises each font byte MSB first.
//
// State table:
//   IDLE     | no fetch in progress, waiting for line_start or a cell load
//   RD_CODE  | vram_rd asserted, vram_addr = ptr
//   LAT_CODE | character code arrives from VRAM and is latched
//   LAT_FONT | cg_en asserted, font byte latched into pending, ptr/col advance
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   ce_pix                pixel clock enable
//   line_start            start of a display line; samples row_base/row_line
//   de                    active display (qualified by ce_pix)
//   row_base, row_line    VRAM address of column 0, scan line within the row
//   reverse               invert active pixels
//   vram_addr, vram_rd    VRAM read port (data returns next clk on vram_data)
//   cg_addr, cg_en        CG ROM address {code, line}, output enable
//   cg_data               CG ROM data, combinational
//   pix                   serial pixel
//   underrun              pulse when a cell loads with no font byte pending

module cg_fetch_sequencer #(
  parameter int COLS    = 40,
  parameter int VRAM_AW = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce_pix,
  input  logic               line_start,
  input  logic               de,
  input  logic [VRAM_AW-1:0] row_base,
  input  logic [2:0]         row_line,
  input  logic               reverse,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_rd,
  input  logic [7:0]         vram_data,
  output logic [10:0]        cg_addr,
  output logic               cg_en,
  input  logic [7:0]         cg_data,
  output logic               pix,
  output logic               underrun
);

  localparam int CW = $clog2(COLS + 1);
  localparam logic [CW-1:0] COLS_C = CW'(COLS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CODE  = 2'd1,
    LAT_CODE = 2'd2,
    LAT_FONT = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      col;
  logic [VRAM_AW-1:0] ptr;
  logic [2:0]         phase;
  logic [2:0]         line;
  logic [7:0]         code;
  logic [7:0]         shift;
  logic [7:0]         pending;
  logic               pending_valid;
  logic               cell_load;
  logic               fetch_trig;

  // A cell load happens on the first pixel of every cell while display is active.
  assign cell_load  = ce_pix & de & (phase == 3'd0);
  assign fetch_trig = cell_load & (col < COLS_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vram_rd   = 1'b0;
    cg_en     = 1'b0;
    vram_addr = ptr;
    cg_addr   = {code, line};
    case (state)
      IDLE:     if (fetch_trig) state_nxt = RD_CODE;
      RD_CODE:  begin
        vram_rd   = 1'b1;
        state_nxt = LAT_CODE;
      end
      LAT_CODE: state_nxt = LAT_FONT;
      LAT_FONT: begin
        cg_en     = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
    // line_start aborts whatever fetch is running and restarts the row.
    if (line_start) state_nxt = RD_CODE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      ptr           <= '0;
      phase         <= 3'd0;
      line          <= 3'd0;
      code          <= 8'h00;
      shift         <= 8'h00;
      pending       <= 8'h00;
      pending_valid <= 1'b0;
      pix           <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      underrun <= cell_load & ~pending_valid;

      if (ce_pix) begin
        if (de) begin
          if (phase == 3'd0) begin
            // A missing font byte shows as a blank cell rather than stale data.
            if (pending_valid) begin
              shift <= {pending[6:0], 1'b0};
              pix   <= pending[7] ^ reverse;
            end else begin
              shift <= 8'h00;
              pix   <= reverse;
            end
            pending_valid <= 1'b0;
          end else begin
            shift <= {shift[6:0], 1'b0};
            pix   <= shift[7] ^ reverse;
          end
          phase <= phase + 3'd1;
        end else begin
          pix   <= 1'b0;
          phase <= 3'd0;
        end
      end

      if (state == LAT_CODE) code <= vram_data;

      // A fetch finishes at least 5 clk before the next cell load, so the
      // set here never collides with the clear in the pixel path.
      if (state == LAT_FONT) begin
        pending       <= cg_data;
        pending_valid <= 1'b1;
        ptr           <= ptr + VRAM_AW'(1);
        col           <= col + CW'(1);
      end

      if (line_start) begin
        ptr           <= row_base;
        line          <= row_line;
        col           <= '0;
        pending_valid <= 1'b0;
        phase         <= 3'd0;
      end
    end
  end

endmodule
